// File: rtl/vin_pwm_pkg.sv
// Shared constants and helpers for the vin PWM plugin input-conditioning logic.
package vin_pwm_pkg;

  localparam int unsigned IDLE_CNT_W   = 32;
  localparam int unsigned GLITCH_CNT_W = 16;

  // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
  function automatic int unsigned clog2(input longint unsigned value);
    longint unsigned v;
    int unsigned     r;
    v = (value > 64'd1) ? (value - 64'd1) : 64'd0;
    r = 32'd0;
    for (int i = 0; i < 64; i++) begin
      if (v != 64'd0) begin
        r = r + 32'd1;
        v = v >> 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vin_pwm_sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous pin into the clk domain.
module vin_pwm_sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_r;

  // Shift the raw pin through the synchroniser flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/vin_pwm_input_filter.sv
// Synchronise, deglitch and edge-detect the raw PWM pin; flag a static input.
// Optional glitch counter output enabled by VIN_PWM_FILTER_GLITCH_COUNT_EN.
module vin_pwm_input_filter
  import vin_pwm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SIGNAL,
  output logic sig_out,
  output logic rise,
  output logic fall,
  output logic stalled
`ifdef VIN_PWM_FILTER_GLITCH_COUNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

  localparam int unsigned FCNT_W = clog2(64'(FILTER_CYCLES) + 64'd1);
  localparam logic [FCNT_W-1:0]     FILTER_MAX  = FCNT_W'(FILTER_CYCLES);
  localparam logic [IDLE_CNT_W-1:0] TIMEOUT_MAX = IDLE_CNT_W'(TIMEOUT_CYCLES);

  logic                  s_s;
  logic [FCNT_W-1:0]     fcnt_r, fcnt_nxt_s, fcnt_inc_s;
  logic [IDLE_CNT_W-1:0] icnt_r, icnt_nxt_s;
  logic                  sig_out_r, sig_nxt_s;
  logic                  rise_r, rise_nxt_s;
  logic                  fall_r, fall_nxt_s;
  logic                  stalled_r, stalled_nxt_s;
  logic                  accept_s;

  vin_pwm_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (SIGNAL),
    .q    (s_s)
  );

  // Persistence filter, edge strobes and saturating idle timer
  always_comb begin
    fcnt_inc_s    = fcnt_r + {{(FCNT_W-1){1'b0}}, 1'b1};
    fcnt_nxt_s    = fcnt_r;
    sig_nxt_s     = sig_out_r;
    accept_s      = 1'b0;
    icnt_nxt_s    = icnt_r;

    if (s_s == sig_out_r) begin
      fcnt_nxt_s = '0;
    end else if (fcnt_inc_s == FILTER_MAX) begin
      accept_s   = 1'b1;
      sig_nxt_s  = s_s;
      fcnt_nxt_s = '0;
    end else begin
      fcnt_nxt_s = fcnt_inc_s;
    end

    // An accepted edge beats saturation, so stalled never rises on an edge cycle
    if (accept_s) begin
      icnt_nxt_s = '0;
    end else if (icnt_r == TIMEOUT_MAX) begin
      icnt_nxt_s = icnt_r;
    end else begin
      icnt_nxt_s = icnt_r + 32'd1;
    end

    rise_nxt_s    = accept_s & s_s;
    fall_nxt_s    = accept_s & ~s_s;
    stalled_nxt_s = (icnt_nxt_s == TIMEOUT_MAX);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_r    <= '0;
      icnt_r    <= '0;
      sig_out_r <= 1'b0;
      rise_r    <= 1'b0;
      fall_r    <= 1'b0;
      stalled_r <= 1'b0;
    end else begin
      fcnt_r    <= fcnt_nxt_s;
      icnt_r    <= icnt_nxt_s;
      sig_out_r <= sig_nxt_s;
      rise_r    <= rise_nxt_s;
      fall_r    <= fall_nxt_s;
      stalled_r <= stalled_nxt_s;
    end
  end

  assign sig_out = sig_out_r;
  assign rise    = rise_r;
  assign fall    = fall_r;
  assign stalled = stalled_r;

`ifdef VIN_PWM_FILTER_GLITCH_COUNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_r, glitch_nxt_s;

  // A filter count abandoned because s fell back to sig_out is one glitch
  always_comb begin
    glitch_nxt_s = glitch_r;
    if ((fcnt_r != '0) && (s_s == sig_out_r) && (glitch_r != {GLITCH_CNT_W{1'b1}})) begin
      glitch_nxt_s = glitch_r + 16'd1;
    end else begin
      glitch_nxt_s = glitch_r;
    end
  end

  // Glitch counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_r <= '0;
    end else begin
      glitch_r <= glitch_nxt_s;
    end
  end

  assign glitch_cnt = glitch_r;
`endif

endmodule

// File: doc/vin_pwm_input_filter.md
Name: vin_pwm_input_filter

Overview:
Input-conditioning stage placed directly upstream of the PWM duty/period counter in the vin PWM plugin. Takes the raw asynchronous pin signal, synchronises it, rejects glitches shorter than a programmable number of clocks, and produces a clean level plus single-cycle rise/fall strobes. A stall flag tells downstream logic that no edge has arrived within a timeout, meaning the input is static at 0 % or 100 %.

Parameters:
SYNC_STAGES, 2, flip-flops in the input synchroniser chain; legal range 2..4.
FILTER_CYCLES, 4, consecutive synchronised cycles a new level must persist before it is accepted; legal range 1..65535.
TIMEOUT_CYCLES, 1000000, clocks without a filtered edge before stall asserts; legal range 1..2^32-1.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
SIGNAL  input  1  raw pin, asynchronous to clk.
sig_out  output  1  filtered, synchronous level (this feeds the counter's SIGNAL input).
rise  output  1  one-cycle strobe on a 0->1 transition of sig_out.
fall  output  1  one-cycle strobe on a 1->0 transition of sig_out.
stalled  output  1  high while no filtered edge has occurred for TIMEOUT_CYCLES clocks.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). Assertion immediately forces the sync chain to 0, sig_out=0, rise=0, fall=0, stalled=0, and both counters to 0. Deassertion is used directly with no internal reset synchroniser.
- Synchroniser: SYNC_STAGES-deep shift register. Call its last stage s.
- Filter counter fcnt has width clog2(FILTER_CYCLES+1).
  - If s==sig_out, then fcnt<=0.
  - Otherwise fcnt<=fcnt+1. When fcnt+1==FILTER_CYCLES, then sig_out<=s and fcnt<=0 in the same edge.
- Latency: a clean step on SIGNAL, sampled first at edge E0, appears on sig_out at edge E0+SYNC_STAGES+FILTER_CYCLES-1.
- Glitch rejection: any pulse at s lasting fewer than FILTER_CYCLES cycles does not change sig_out.
- rise/fall are registered and asserted in the same cycle in which sig_out changes, for exactly one cycle. They are never both high.
- Idle counter icnt is 32-bit.
  - It is cleared on the cycle rise or fall is asserted.
  - Otherwise it increments and saturates at TIMEOUT_CYCLES (no wrap).
  - stalled=1 whenever icnt==TIMEOUT_CYCLES. It drops the cycle the next rise/fall is asserted.
- After reset, stalled asserts TIMEOUT_CYCLES clocks after rst_n deasserts if SIGNAL stays low.
- Simultaneous events: if an edge is accepted on the same cycle icnt would reach saturation, the clear wins and stalled stays 0.
- Reset mid-filter: a pending fcnt count is discarded. After release, a sustained SIGNAL=1 needs the full latency again.

Optional Feature:
Macro VIN_PWM_FILTER_GLITCH_COUNT_EN.
- Defined:
  - Adds output glitch_cnt [15:0], reset to 0.
  - It increments by 1 on every cycle where fcnt!=0 and s==sig_out, i.e. an aborted transition.
  - It saturates at 16'hFFFF.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package vin_pwm_pkg holds:
  - the idle-counter width constant (32);
  - the glitch-counter width constant (16);
  - a clog2 helper function.
- One natural sub-module is vin_pwm_sync_chain (parameter SYNC_STAGES; ports clk, rst_n, d, q). It is reusable by other vin plugins.

Test Plan (all scenarios use defaults, except TIMEOUT_CYCLES=1000):
- Reset: hold rst_n=0 with SIGNAL toggling -> sig_out, rise, fall and stalled stay 0. With the macro on, glitch_cnt=0.
- Clean step: SIGNAL 0->1 held, first sampled at edge E0 -> sig_out=1 and rise=1 at edge E0+5; rise=0 at E0+6. fall is never asserted.
- Glitch: SIGNAL high for 3 clocks, then low -> sig_out stays 0 and no strobe. With the macro on, glitch_cnt=1.
- Square wave with period 200 clocks (100 high / 100 low), run for 10000 clocks -> sig_out is the same waveform delayed 5 clocks. Expect 50 rise and 50 fall strobes, alternating, and stalled never asserts.
- Stall: hold SIGNAL=0 after reset -> stalled=1 exactly 1000 clocks after rst_n release. A later accepted rise clears stalled in the same cycle.
- Async reset mid-filter: assert rst_n low 2 clocks into a 0->1 step, then release -> sig_out rises 5 clocks after the first post-release sampling edge. Pre-reset progress is not counted.
